// File: rtl/pipe_stage_buf_if.sv
// Valid/ready stage-to-stage bundle for pipe_stage_buf.
// The slave side is the stage itself. The master side is the surrounding pipeline.
interface pipe_stage_buf_if #(
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_halt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_halt;

    modport master (
        output in_valid, in_data, in_halt, out_ready,
        input  in_ready, out_valid, out_data, out_halt
    );

    modport slave (
        input  in_valid, in_data, in_halt, out_ready,
        output in_ready, out_valid, out_data, out_halt
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Two-entry skid-buffered pipeline stage register with flush and sticky halt.
// Define PIPE_PERF_CNT_EN to add the CNT_W parameter and the saturating stall_cnt output.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | nothing buffered, out_valid=0
// ST_ONE   | head register H holds the only beat
// ST_TWO   | H holds the older beat, skid register S the newer
module pipe_stage_buf #(
    parameter int DATA_W = 128
`ifdef PIPE_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  flush,
    pipe_stage_buf_if.slave       bus,
    output logic [1:0]            occupancy,
    output logic                  halted
`ifdef PIPE_PERF_CNT_EN
    , output logic [CNT_W-1:0]    stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_h_data;
    logic              r_h_halt;
    logic [DATA_W-1:0] r_s_data;
    logic              r_s_halt;
    logic              r_in_ready;
    logic              r_halt_pend;
    logic              r_halted;

    logic w_accept;
    logic w_xfer;
    logic w_halt_out;
    logic w_ld_h_in;
    logic w_ld_h_s;
    logic w_ld_s_in;
    logic w_halt_pend_nxt;
    logic w_in_ready_nxt;

    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_xfer     = bus.out_valid & bus.out_ready;
    assign w_halt_out = w_xfer & r_h_halt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ld_h_in       = 1'b0;
        w_ld_h_s        = 1'b0;
        w_ld_s_in       = 1'b0;
        w_halt_pend_nxt = r_halt_pend;

        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_ld_h_in   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_xfer) begin
                        w_ld_h_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_TWO;
                        w_ld_s_in   = 1'b1;
                    end else if (w_xfer) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_xfer) begin
                        w_state_nxt = ST_ONE;
                        w_ld_h_s    = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end

        // A flush only cancels the pending halt if the halt beat never left the stage.
        if (flush) begin
            w_halt_pend_nxt = r_halt_pend & (r_halted | w_halt_out);
        end else if (w_accept && bus.in_halt) begin
            w_halt_pend_nxt = 1'b1;
        end

        w_in_ready_nxt = (w_state_nxt != ST_TWO) && !w_halt_pend_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_h_data    <= '0;
            r_h_halt    <= 1'b0;
            r_s_data    <= '0;
            r_s_halt    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_halt_pend <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            if (w_ld_h_in) begin
                r_h_data <= bus.in_data;
                r_h_halt <= bus.in_halt;
            end else if (w_ld_h_s) begin
                r_h_data <= r_s_data;
                r_h_halt <= r_s_halt;
            end
            if (w_ld_s_in) begin
                r_s_data <= bus.in_data;
                r_s_halt <= bus.in_halt;
            end
            r_in_ready  <= w_in_ready_nxt;
            r_halt_pend <= w_halt_pend_nxt;
            r_halted    <= r_halted | w_halt_out;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (bus.out_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign bus.out_data  = r_h_data;
    assign bus.out_halt  = r_h_halt;
    assign occupancy     = r_state;
    assign halted        = r_halted;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: streaming, back-pressure, flush, halt and reset.
// With PIPE_PERF_CNT_EN defined it also checks the saturating stall counter at CNT_W=4.
module tb_pipe_stage_buf;

    localparam int DATA_W = 128;

    logic       CLK;
    logic       RST;
    logic       flush;
    logic [1:0] occupancy;
    logic       halted;
`ifdef PIPE_PERF_CNT_EN
    logic [3:0] stall_cnt;
`endif

    int n_vec;
    int n_err;

    pipe_stage_buf_if #(.DATA_W(DATA_W)) bus ();

`ifdef PIPE_PERF_CNT_EN
    pipe_stage_buf #(.DATA_W(DATA_W), .CNT_W(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy),
        .halted    (halted),
        .stall_cnt (stall_cnt)
    );
`else
    pipe_stage_buf #(.DATA_W(DATA_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy),
        .halted    (halted)
    );
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] d, input logic h);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_halt  = h;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RST   = 1'b1;
        flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        bus.out_ready = 1'b0;
        step();
        step();
        RST = 1'b0;

        chk("rst_occ",    128'(occupancy),     128'd0);
        chk("rst_ovalid", 128'(bus.out_valid), 128'd0);
        chk("rst_iready", 128'(bus.in_ready),  128'd1);
        chk("rst_odata",  bus.out_data,        128'd0);
        chk("rst_ohalt",  128'(bus.out_halt),  128'd0);
        chk("rst_halted", 128'(halted),        128'd0);

        // streaming at full rate
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 128'(i), 1'b0);
            step();
            chk($sformatf("stream_data%0d", i),  bus.out_data,        128'(i));
            chk($sformatf("stream_valid%0d", i), 128'(bus.out_valid), 128'd1);
            chk($sformatf("stream_ready%0d", i), 128'(bus.in_ready),  128'd1);
            chk($sformatf("stream_occ%0d", i),   128'(occupancy),     128'd1);
        end
        drive(1'b0, '0, 1'b0);
        step();
        chk("stream_drain_occ",  128'(occupancy), 128'd0);
        chk("stream_hold_data",  bus.out_data,    128'h8);

        // back-pressure
        bus.out_ready = 1'b0;
        drive(1'b1, 128'hA, 1'b0);
        step();
        chk("bp_occ1",   128'(occupancy),    128'd1);
        chk("bp_ready1", 128'(bus.in_ready), 128'd1);
        drive(1'b1, 128'hB, 1'b0);
        step();
        chk("bp_occ2",   128'(occupancy),    128'd2);
        chk("bp_ready2", 128'(bus.in_ready), 128'd0);
        chk("bp_head",   bus.out_data,       128'hA);
        drive(1'b1, 128'hF, 1'b0);
        step();
        chk("bp_stable_data", bus.out_data,    128'hA);
        chk("bp_stable_occ",  128'(occupancy), 128'd2);
        drive(1'b0, '0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        chk("bp_out_b",   bus.out_data,       128'hB);
        chk("bp_occ_b",   128'(occupancy),    128'd1);
        chk("bp_ready_b", 128'(bus.in_ready), 128'd1);
        step();
        chk("bp_empty",   128'(bus.out_valid), 128'd0);
        chk("bp_hold",    bus.out_data,        128'hB);

        // flush beats priority over simultaneous accept
        bus.out_ready = 1'b0;
        drive(1'b1, 128'hC, 1'b0);
        step();
        drive(1'b1, 128'hD, 1'b0);
        step();
        chk("fl_pre_occ", 128'(occupancy), 128'd2);
        drive(1'b1, 128'hE, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        chk("fl_occ",    128'(occupancy),     128'd0);
        chk("fl_valid",  128'(bus.out_valid), 128'd0);
        chk("fl_data",   bus.out_data,        128'hC);
        chk("fl_ready",  128'(bus.in_ready),  128'd1);
        step();
        chk("fl_no_e_valid", 128'(bus.out_valid), 128'd0);
        chk("fl_no_e_data",  bus.out_data,        128'hC);

        // halt: 0x6 carries halt, 0x7 must be refused
        drive(1'b1, 128'h5, 1'b0);
        step();
        drive(1'b1, 128'h6, 1'b1);
        step();
        chk("ht_occ2",   128'(occupancy),    128'd2);
        chk("ht_ready0", 128'(bus.in_ready), 128'd0);
        drive(1'b1, 128'h7, 1'b0);
        step();
        chk("ht_occ_keep", 128'(occupancy), 128'd2);
        bus.out_ready = 1'b1;
        step();
        chk("ht_head6",     bus.out_data,       128'h6);
        chk("ht_ohalt",     128'(bus.out_halt), 128'd1);
        chk("ht_halted0",   128'(halted),       128'd0);
        chk("ht_ready_pend",128'(bus.in_ready), 128'd0);
        step();
        chk("ht_halted1",   128'(halted),        128'd1);
        chk("ht_empty",     128'(bus.out_valid), 128'd0);
        chk("ht_no7",       bus.out_data,        128'h6);
        chk("ht_ready_stk", 128'(bus.in_ready),  128'd0);
        drive(1'b0, '0, 1'b0);
        bus.out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("ht_flush_halted", 128'(halted),       128'd1);
        chk("ht_flush_ready",  128'(bus.in_ready), 128'd0);

        // reset mid-operation with occupancy 2 and a halt pending
        do_reset();
        chk("rm_pre_halted", 128'(halted), 128'd0);
        drive(1'b1, 128'h1, 1'b0);
        step();
        drive(1'b1, 128'h2, 1'b1);
        step();
        chk("rm_pre_occ",   128'(occupancy),    128'd2);
        chk("rm_pre_ready", 128'(bus.in_ready), 128'd0);
        drive(1'b0, '0, 1'b0);
        do_reset();
        chk("rm_occ",    128'(occupancy),     128'd0);
        chk("rm_valid",  128'(bus.out_valid), 128'd0);
        chk("rm_ready",  128'(bus.in_ready),  128'd1);
        chk("rm_data",   bus.out_data,        128'd0);
        chk("rm_ohalt",  128'(bus.out_halt),  128'd0);
        chk("rm_halted", 128'(halted),        128'd0);

        // flush of a still-buffered halt beat reopens the stage
        drive(1'b1, 128'h3, 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        chk("fh_ready0", 128'(bus.in_ready), 128'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fh_occ",    128'(occupancy),    128'd0);
        chk("fh_ready1", 128'(bus.in_ready), 128'd1);
        chk("fh_halted", 128'(halted),       128'd0);

`ifdef PIPE_PERF_CNT_EN
        do_reset();
        chk("pc_rst0", 128'(stall_cnt), 128'd0);
        drive(1'b1, 128'h9, 1'b0);
        step();
        drive(1'b0, '0, 1'b0);
        repeat (5) step();
        chk("pc_cnt5", 128'(stall_cnt), 128'd5);
        repeat (15) step();
        chk("pc_sat", 128'(stall_cnt), 128'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("pc_flush_keep", 128'(stall_cnt), 128'd15);
        do_reset();
        chk("pc_rst", 128'(stall_cnt), 128'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
